// File: rtl/hq2x_scan_pkg.sv
// hq2x_scan_pkg: FSM state constants and lost-sync limit for the Hq2x scan-out sequencer
package hq2x_scan_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_LINE0 = 2'd2;
  localparam logic [1:0] ST_LINE1 = 2'd3;
  function automatic logic [15:0] lost_limit(input logic [15:0] p);
    return p + (p >> 2);
  endfunction
endpackage

// File: rtl/hq2x_line_meter.sv
// hq2x_line_meter: input edge detection plus saturating line-period and active-width meters
module hq2x_line_meter #(
  parameter int LW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_in_i,
  input  logic          ce_out_i,
  input  logic          hb_i,
  input  logic          hs_i,
  input  logic          vs_i,
  output logic [LW-1:0] period_o,
  output logic [LW-1:0] width_o,
  output logic          valid_o,
  output logic          hs_evt_o,
  output logic          hb_fall_o,
  output logic          vs_fall_o,
  output logic          hb_o,
  output logic          vs_o
);
  localparam logic [LW-1:0] ONES = '1;
  logic hb_q, hs_q, vs_q, hs_pend_q, valid_q;
  logic [LW-1:0] pcnt_q, wcnt_q, period_q, width_q, pcnt_inc, wcnt_inc;
  logic hs_rise, hb_rise;
  assign hs_rise   = hs_i & ~hs_q;
  assign hb_rise   = hb_i & ~hb_q;
  assign hs_evt_o  = hs_rise | hs_pend_q;
  assign hb_fall_o = ~hb_i & hb_q;
  assign vs_fall_o = ~vs_i & vs_q;
  assign pcnt_inc  = (pcnt_q == ONES) ? ONES : pcnt_q + 1'b1;
  assign wcnt_inc  = (wcnt_q == ONES) ? ONES : wcnt_q + 1'b1;
  assign period_o  = period_q;
  assign width_o   = width_q;
  assign valid_o   = valid_q;
  assign hb_o      = hb_q;
  assign vs_o      = vs_q;
  // one-clock input history; an hsync edge between ce_out ticks is held until the next tick
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hb_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      hs_pend_q <= 1'b0;
    end else begin
      hb_q <= hb_i;
      hs_q <= hs_i;
      vs_q <= vs_i;
      hs_pend_q <= ~ce_out_i & hs_evt_o;
    end
  // period in ce_out ticks between hsync edges; a saturated count is not a usable period
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pcnt_q <= '0;
      period_q <= '0;
      valid_q <= 1'b0;
    end else if (ce_out_i) begin
      pcnt_q <= hs_evt_o ? '0 : pcnt_inc;
      if (hs_evt_o) begin
        period_q <= pcnt_inc;
        valid_q <= pcnt_inc != ONES;
      end
    end
  // active width in ce_in ticks, restarted at hblank end and captured at hblank start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wcnt_q <= '0;
      width_q <= '0;
    end else begin
      if (hb_fall_o) wcnt_q <= ce_in_i ? LW'(1) : '0;
      else if (ce_in_i && !hb_i) wcnt_q <= wcnt_inc;
      if (hb_rise) width_q <= wcnt_q;
    end
endmodule

// File: rtl/hq2x_scan_out.sv
// hq2x_scan_out: Hq2x read-side sequencer emitting two output lines per input line; HQ2X_SCANLINES_EN adds the scanline flag
module hq2x_scan_out
  import hq2x_scan_pkg::*;
#(
  parameter int LW     = 12,
  parameter int HS_W   = 48,
  parameter int HB_OFS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_in,
  input  logic       ce_out,
  input  logic       hb_in,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic       reset_line,
  output logic       reset_frame,
  output logic [1:0] read_y,
  output logic       hblank,
  output logic       hs_out,
  output logic       vs_out,
  output logic       scanline
);
  localparam int OW = LW + 1;
  logic [LW-1:0] period, width;
  logic valid, hs_evt, hb_fall, vs_fall;
  logic [1:0] state_q, state_d;
  logic [OW-1:0] ocnt_q, ocnt_d, half;
  logic [OW:0] win_end;
  logic [15:0] lim;
  logic bufsel_q, bufsel_d, in_line, active_d;
  logic hblank_q, hs_out_q, vs_out_q, ry_half_q, ry_row_q;
  hq2x_line_meter #(.LW(LW)) u_meter (
    .clk(clk),
    .rst(rst),
    .ce_in_i(ce_in),
    .ce_out_i(ce_out),
    .hb_i(hb_in),
    .hs_i(hs_in),
    .vs_i(vs_in),
    .period_o(period),
    .width_o(width),
    .valid_o(valid),
    .hs_evt_o(hs_evt),
    .hb_fall_o(hb_fall),
    .vs_fall_o(vs_fall),
    .hb_o(reset_line),
    .vs_o(reset_frame)
  );
  assign half     = OW'(period >> 1);
  assign win_end  = (OW+1)'(HB_OFS) + (OW+1)'({width, 1'b0});
  assign lim      = lost_limit(16'(period));
  assign bufsel_d = vs_fall ? 1'b0 : bufsel_q ^ hb_fall;
  assign in_line  = state_d[1];
  assign active_d = in_line && ocnt_d >= OW'(HB_OFS) && ocnt_d < half && {1'b0, ocnt_d} < win_end;
  assign read_y   = {ry_half_q, ry_row_q};
  assign hblank   = hblank_q;
  assign hs_out   = hs_out_q;
  assign vs_out   = vs_out_q;
  // line sequencing: hsync always restarts LINE0, half-period starts LINE1, long silence drops to WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = valid ? ST_WAIT : ST_IDLE;
      ST_WAIT:  state_d = hs_evt ? ST_LINE0 : ST_WAIT;
      ST_LINE0: state_d = (hs_evt || ocnt_q != half) ? ST_LINE0 : ST_LINE1;
      default:  state_d = hs_evt ? ST_LINE0 : (16'(ocnt_q) >= lim) ? ST_WAIT : ST_LINE1;
    endcase
    ocnt_d = (hs_evt || state_d != state_q) ? '0 : ocnt_q + 1'b1;
  end
  // FSM and line-aligned outputs, all advancing on ce_out ticks
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      ocnt_q <= '0;
      hblank_q <= 1'b1;
      hs_out_q <= 1'b0;
      vs_out_q <= 1'b0;
      ry_row_q <= 1'b0;
    end else if (ce_out) begin
      state_q <= state_d;
      ocnt_q <= ocnt_d;
      hblank_q <= ~active_d;
      hs_out_q <= in_line && ocnt_d < OW'(HS_W);
      ry_row_q <= state_d == ST_LINE1;
      if (hs_evt && state_d == ST_LINE0) vs_out_q <= vs_in;
    end
  // buffer half written by the Hq2x writer; the reader takes the other, completed half
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bufsel_q <= 1'b0;
      ry_half_q <= 1'b0;
    end else begin
      bufsel_q <= bufsel_d;
      ry_half_q <= ~bufsel_d;
    end
`ifdef HQ2X_SCANLINES_EN
  logic scan_q;
  // odd sub-row active flag, registered alongside hblank
  always_ff @(posedge clk or posedge rst)
    if (rst) scan_q <= 1'b0;
    else if (ce_out) scan_q <= state_d == ST_LINE1 && active_d;
  assign scanline = scan_q;
`else
  assign scanline = 1'b0;
`endif
endmodule
